// File: rtl/dispatch_arbiter.sv
// dispatch_arbiter: shares one network-source packet input among NUM_REQ requesters.
// Bursts of SPK packets are atomic up to a terminator (any non-SPK opcode), bursts are
// granted round-robin, and a single output register drives src/src_valid.
module dispatch_arbiter #(
    parameter int unsigned PKT_WIDTH    = 16,
    parameter int unsigned PFX_WIDTH    = 2,
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned IDLE_TIMEOUT = 0
) (
    input  logic                              clk,
    input  logic                              arstn,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ-1:0][PKT_WIDTH-1:0] req_pkt_i,
    output logic                              src_valid_o,
    input  logic                              src_ready_i,
    output logic [PKT_WIDTH-1:0]              src_o,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id_o,
    output logic                              locked_o,
    output logic                              timeout_o
);

    localparam int unsigned IdW       = $clog2(NUM_REQ);
    localparam bit          TimeoutEn = (IDLE_TIMEOUT != 0);
    // Counter only needs to reach IDLE_TIMEOUT-1; the next idle cycle fires.
    localparam int unsigned CntW      = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam int unsigned CntLast   = TimeoutEn ? IDLE_TIMEOUT - 1 : 0;
    // SPK is the only non-terminating opcode; RUN/FIN/CLR all end a burst.
    localparam logic [PFX_WIDTH-1:0] OpcSpk = '0;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    state_e               state_q, state_d;
    logic [IdW-1:0]       grant_q, grant_d;
    logic [IdW-1:0]       rr_q, rr_d;
    logic [CntW-1:0]      idle_q, idle_d;
    logic                 timeout_q, timeout_d;
    logic                 src_valid_q, src_valid_d;
    logic [PKT_WIDTH-1:0] src_q, src_d;

    logic                 out_free;
    logic                 win_found;
    logic [IdW-1:0]       win_idx;
    logic [IdW-1:0]       owner;
    logic                 owner_ok;
    logic                 accept;
    logic [PKT_WIDTH-1:0] acc_pkt;
    logic                 acc_term;
    logic [NUM_REQ-1:0]   ready_raw;

    function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
        if (32'(id) == NUM_REQ - 1) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

    // Round-robin search for the first valid requester at or above the rr pointer.
    always_comb begin
        int unsigned    cand;
        logic [IdW-1:0] cand_id;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_id   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand    = (32'(rr_q) + 32'(k)) % NUM_REQ;
            cand_id = IdW'(cand);
            if (!win_found && req_valid_i[cand_id]) begin
                win_found = 1'b1;
                win_idx   = cand_id;
            end
        end
    end

    // Select the single requester allowed to transfer this cycle and decode its packet.
    always_comb begin
        out_free  = !src_valid_q || src_ready_i;
        owner     = (state_q == StLocked) ? grant_q : win_idx;
        // A locked grantee is offered ready even while it is not presenting a packet.
        owner_ok  = (state_q == StLocked) || win_found;
        accept    = owner_ok && out_free && req_valid_i[owner];
        acc_pkt   = req_pkt_i[owner];
        acc_term  = (acc_pkt[PKT_WIDTH-1 -: PFX_WIDTH] != OpcSpk);
        ready_raw = '0;
        if (owner_ok && out_free) begin
            ready_raw[owner] = 1'b1;
        end
    end

    // Nothing is accepted while reset is held, even though the output stage looks free.
    assign req_ready_o = arstn ? ready_raw : '0;

    // Next-state: output register, burst lock, round-robin pointer and idle timeout.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        idle_d      = idle_q;
        timeout_d   = 1'b0;
        src_valid_d = src_valid_q;
        src_d       = src_q;

        // A new accept replaces a draining packet in the same cycle, so no bubble.
        if (accept) begin
            src_valid_d = 1'b1;
            src_d       = acc_pkt;
        end else if (src_valid_q && src_ready_i) begin
            src_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                idle_d = '0;
                if (accept) begin
                    grant_d = owner;
                    if (acc_term) begin
                        rr_d = next_id(owner);
                    end else begin
                        state_d = StLocked;
                    end
                end
            end
            StLocked: begin
                if (accept) begin
                    idle_d = '0;
                    if (acc_term) begin
                        state_d = StIdle;
                        rr_d    = next_id(grant_q);
                    end
                end else if (TimeoutEn && !req_valid_i[grant_q]) begin
                    if (idle_q == CntW'(CntLast)) begin
                        // Revoke the lock; a packet already in the output register still drains.
                        state_d   = StIdle;
                        rr_d      = next_id(grant_q);
                        idle_d    = '0;
                        timeout_d = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight packet.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_q        <= '0;
            idle_q      <= '0;
            timeout_q   <= 1'b0;
            src_valid_q <= 1'b0;
            src_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            idle_q      <= idle_d;
            timeout_q   <= timeout_d;
            src_valid_q <= src_valid_d;
            src_q       <= src_d;
        end
    end

    assign src_valid_o = src_valid_q;
    assign src_o       = src_q;
    assign grant_id_o  = grant_q;
    assign locked_o    = (state_q == StLocked);
    assign timeout_o   = timeout_q;

    // A stalled packet must stay put until the source takes it.
    a_hold_stable: assert property (@(posedge clk) disable iff (!arstn)
        src_valid_o && !src_ready_i |=> src_valid_o && $stable(src_o));

    // At most one requester is ever offered the output.
    a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready_o));

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Bench for dispatch_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a behavioural burst/round-robin model.
module tb_dispatch_arbiter;

    localparam int NREQ = 2;
    localparam int TO   = 4;

    logic             clk;
    logic             arstn;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready_o;
    logic [1:0][15:0] req_pkt;
    logic             src_valid_o;
    logic             src_ready;
    logic [15:0]      src_o;
    logic [0:0]       grant_id_o;
    logic             locked_o;
    logic             timeout_o;

    dispatch_arbiter #(
        .PKT_WIDTH   (16),
        .PFX_WIDTH   (2),
        .NUM_REQ     (NREQ),
        .IDLE_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .arstn      (arstn),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready_o),
        .req_pkt_i  (req_pkt),
        .src_valid_o(src_valid_o),
        .src_ready_i(src_ready),
        .src_o      (src_o),
        .grant_id_o (grant_id_o),
        .locked_o   (locked_o),
        .timeout_o  (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input int op, input int id, input int seq);
        return {2'(op), 2'(id), 12'(seq)};
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_sv;
    logic [15:0] m_src;
    int          m_gid, m_rr, m_idle;
    bit          m_lk, m_to;

    always @(negedge clk) begin
        int          own;
        bit          has, of, acc, term;
        logic [1:0]  e_rdy;
        logic [15:0] p;
        if (!arstn) begin
            m_sv = 0; m_src = '0; m_gid = 0; m_rr = 0; m_idle = 0; m_lk = 0; m_to = 0;
            chk("rst_req_ready", req_ready_o, 0);
            chk("rst_src_valid", src_valid_o, 0);
            chk("rst_src", src_o, 0);
            chk("rst_grant_id", grant_id_o, 0);
            chk("rst_locked", locked_o, 0);
            chk("rst_timeout", timeout_o, 0);
        end else begin
            of  = !m_sv || src_ready;
            has = 0;
            own = 0;
            if (m_lk) begin
                has = 1;
                own = m_gid;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!has && req_valid[(m_rr + k) % NREQ]) begin
                        has = 1;
                        own = (m_rr + k) % NREQ;
                    end
                end
            end
            e_rdy = '0;
            if (has && of) e_rdy[own] = 1'b1;
            chk("req_ready", req_ready_o, e_rdy);
            chk("src_valid", src_valid_o, m_sv);
            chk("src", src_o, m_src);
            chk("grant_id", grant_id_o, m_gid);
            chk("locked", locked_o, m_lk);
            chk("timeout", timeout_o, m_to);

            acc  = has && of && req_valid[own];
            p    = req_pkt[own];
            term = (p[15:14] != 2'b00);
            m_to = 0;
            if (acc) begin
                m_sv  = 1;
                m_src = p;
            end else if (m_sv && src_ready) begin
                m_sv = 0;
            end
            if (!m_lk) begin
                m_idle = 0;
                if (acc) begin
                    m_gid = own;
                    if (term) m_rr = (own + 1) % NREQ;
                    else m_lk = 1;
                end
            end else if (acc) begin
                m_idle = 0;
                if (term) begin
                    m_lk = 0;
                    m_rr = (m_gid + 1) % NREQ;
                end
            end else if (!req_valid[m_gid]) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_lk   = 0;
                    m_rr   = (m_gid + 1) % NREQ;
                    m_idle = 0;
                    m_to   = 1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int          cyc = 0;
    logic [15:0] beats[$];
    int          beat_cyc[$];
    int          beat_gid[$];
    int          to_cyc[$];
    int          lock_cycles = 0;
    int          lock_rise_cyc = 0;
    bit          prev_locked = 0;

    always @(negedge clk) begin
        cyc++;
        if (arstn) begin
            if (src_valid_o && src_ready) begin
                beats.push_back(src_o);
                beat_cyc.push_back(cyc);
                beat_gid.push_back(int'(grant_id_o));
            end
            if (locked_o) lock_cycles++;
            if (locked_o && !prev_locked) lock_rise_cyc = cyc;
            if (timeout_o) to_cyc.push_back(cyc);
        end
        prev_locked = arstn && locked_o;
    end

    // ---------------- requester driver ----------------
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int vld_pct = 100;
    int rdy_pct = 100;

    task automatic drive(input logic [1:0] acc);
        logic [1:0] hold;
        hold = req_valid & ~acc;
        if (q0.size() > 0 && (hold[0] || $urandom_range(0, 99) < vld_pct)) begin
            req_valid[0] = 1'b1;
            req_pkt[0]   = q0[0];
        end else begin
            req_valid[0] = 1'b0;
        end
        if (q1.size() > 0 && (hold[1] || $urandom_range(0, 99) < vld_pct)) begin
            req_valid[1] = 1'b1;
            req_pkt[1]   = q1[0];
        end else begin
            req_valid[1] = 1'b0;
        end
    endtask

    task automatic step();
        logic [1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready_o;
        @(posedge clk);
        #1;
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
        drive(acc);
        src_ready = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_logs();
        beats.delete();
        beat_cyc.delete();
        beat_gid.delete();
        to_cyc.delete();
        lock_cycles = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        arstn = 1'b0;
        q0.delete();
        q1.delete();
        req_valid = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        arstn = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [15:0] b;
        arstn     = 1'b0;
        req_valid = '0;
        req_pkt   = '0;
        src_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arstn     = 1'b1;
        src_ready = 1'b1;

        // 1: req0 burst SPK,SPK,RUN
        clear_logs();
        q0.push_back(mk(0, 0, 1));
        q0.push_back(mk(0, 0, 2));
        q0.push_back(mk(1, 0, 3));
        steps(7);
        chk("t1_nbeats", beats.size(), 3);
        chk("t1_b0", beats[0], 16'h0001);
        chk("t1_b1", beats[1], 16'h0002);
        chk("t1_b2", beats[2], 16'h4003);
        chk("t1_back2back", beat_cyc[2] - beat_cyc[0], 2);
        chk("t1_lock_cycles", lock_cycles, 2);
        chk("t1_unlocked", locked_o, 0);

        // 2: competing bursts from reset, no interleave
        do_reset();
        clear_logs();
        q0.push_back(mk(0, 0, 1));
        q0.push_back(mk(1, 0, 2));
        q1.push_back(mk(0, 1, 1));
        q1.push_back(mk(2, 1, 2));
        steps(8);
        chk("t2_nbeats", beats.size(), 4);
        chk("t2_b0", beats[0], 16'h0001);
        chk("t2_b1", beats[1], 16'h4002);
        chk("t2_b2", beats[2], 16'h1001);
        chk("t2_b3", beats[3], 16'h9002);
        chk("t2_gid0", beat_gid[0], 0);
        chk("t2_gid1", beat_gid[1], 0);
        chk("t2_gid2", beat_gid[2], 1);
        chk("t2_gid3", beat_gid[3], 1);

        // 3: both stream single RUN packets -> strict alternation
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1, 0, i));
            q1.push_back(mk(1, 1, i));
        end
        steps(12);
        chk("t3_nbeats", beats.size(), 8);
        for (int i = 0; i < 8; i++) begin
            b = beats[i];
            chk("t3_alt", b[13:12], i % 2);
        end

        // 4: source stalls for several cycles
        clear_logs();
        q0.push_back(mk(0, 0, 10));
        q0.push_back(mk(0, 0, 11));
        q0.push_back(mk(3, 0, 12));
        rdy_pct = 0;
        steps(7);
        chk("t4_ready_blocked", req_ready_o, 0);
        chk("t4_held_valid", src_valid_o, 1);
        chk("t4_held_pkt", src_o, 16'h000a);
        chk("t4_no_beats", beats.size(), 0);
        rdy_pct = 100;
        steps(6);
        chk("t4_nbeats", beats.size(), 3);
        chk("t4_b0", beats[0], 16'h000a);
        chk("t4_b1", beats[1], 16'h000b);
        chk("t4_b2", beats[2], 16'hc00c);

        // 5: grantee goes quiet -> timeout, then req0 gets the output
        do_reset();
        clear_logs();
        q1.push_back(mk(0, 1, 5));
        steps(2);
        q0.push_back(mk(1, 0, 6));
        steps(10);
        chk("t5_n_timeouts", to_cyc.size(), 1);
        if (to_cyc.size() == 1) begin
            chk("t5_timeout_delay", to_cyc[0] - lock_rise_cyc, 4);
            chk("t5_nbeats", beats.size(), 2);
            chk("t5_b1", beats[1], 16'h4006);
            chk("t5_req0_next", beat_cyc[1] - to_cyc[0], 1);
        end
        chk("t5_drained", q0.size(), 0);

        // 6: reset in the middle of a req1 burst
        do_reset();
        clear_logs();
        for (int i = 0; i < 3; i++) q1.push_back(mk(0, 1, i));
        q1.push_back(mk(1, 1, 3));
        steps(3);
        chk("t6_pre_locked", locked_o, 1);
        chk("t6_pre_gid", grant_id_o, 1);
        #2;
        arstn = 1'b0;
        #1;
        chk("t6_rst_src_valid", src_valid_o, 0);
        chk("t6_rst_locked", locked_o, 0);
        chk("t6_rst_gid", grant_id_o, 0);
        chk("t6_rst_ready", req_ready_o, 0);
        q0.delete();
        q1.delete();
        req_valid = '0;
        q0.push_back(mk(1, 0, 7));
        q1.push_back(mk(1, 1, 7));
        drive(2'b00);
        @(negedge clk);
        @(posedge clk);
        #1;
        arstn = 1'b1;
        clear_logs();
        steps(5);
        chk("t6_nbeats", beats.size(), 2);
        chk("t6_first_req0", beats[0], 16'h4007);
        chk("t6_then_req1", beats[1], 16'h5007);

        // Randomized traffic with stalls, gaps and one mid-run reset
        vld_pct = 60;
        rdy_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            while (q0.size() < 3)
                q0.push_back(mk($urandom_range(0, 1) ? 0 : $urandom_range(1, 3), 0, c));
            while (q1.size() < 3)
                q1.push_back(mk($urandom_range(0, 1) ? 0 : $urandom_range(1, 3), 1, c));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
